// File: rtl/vec_inst_decode.sv
// Decode stage for the vector ALU path: opcode -> ALU control, then one beat per lane group.
// Optional VEC_DECO_ILLEGAL_TRAP_EN: unmapped opcodes raise a sticky illegal flag instead of issuing a NOP.
module vec_inst_decode #(
   parameter  int VLEN   = 8,
   parameter  int LANES  = 4,
   localparam int NBEATS = VLEN / LANES,
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [3:0]    in_opcode,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [2:0]    out_alu,
   output logic          out_wr,
   output logic          out_cmp,
   output logic [BW-1:0] out_beat,
   output logic          out_last
`ifdef VEC_DECO_ILLEGAL_TRAP_EN
   ,output logic         illegal
`endif
);

   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t        state, state_n;
   logic [2:0]    alu_n;
   logic          wr_n, cmp_n, last_n, load, do_load;
   logic [BW-1:0] beat_n;
   logic [2:0]    dec_alu;
   logic          dec_wr, dec_cmp, dec_vec;
`ifdef VEC_DECO_ILLEGAL_TRAP_EN
   logic          dec_legal, illegal_n;
`endif

   assign out_valid = (state == ISSUE);
   assign in_ready  = (state == IDLE) || (out_last && out_ready);

   always_comb begin
      dec_alu = 3'b000;
      dec_wr  = 1'b0;
      dec_cmp = 1'b0;
      dec_vec = 1'b0;
`ifdef VEC_DECO_ILLEGAL_TRAP_EN
      dec_legal = 1'b1;
`endif
      case (in_opcode)
         4'b0100:          dec_alu = 3'b001;
         4'b1101, 4'b1110: begin dec_alu = 3'b001; dec_wr = 1'b1; dec_vec = 1'b1; end
         4'b1111:          begin dec_alu = 3'b111; dec_wr = 1'b1; dec_vec = 1'b1; end
         4'b1000:          begin dec_alu = 3'b010; dec_wr = 1'b1; dec_vec = 1'b1; end
         4'b1001:          begin dec_alu = 3'b011; dec_wr = 1'b1; dec_vec = 1'b1; end
         4'b1010:          begin dec_alu = 3'b100; dec_wr = 1'b1; dec_vec = 1'b1; end
         4'b1011:          begin dec_alu = 3'b101; dec_wr = 1'b1; dec_vec = 1'b1; end
         4'b0101, 4'b0110: begin dec_alu = 3'b011; dec_cmp = 1'b1; end
         4'b0000, 4'b0001: begin dec_alu = 3'b010; dec_wr = 1'b1; end
         default: begin
`ifdef VEC_DECO_ILLEGAL_TRAP_EN
            dec_legal = 1'b0;
`endif
         end
      endcase
   end

   // Next state: advance the beat on a handshake, or load a new instruction when the last beat leaves.
   always_comb begin
      state_n = state;
      alu_n   = out_alu;
      wr_n    = out_wr;
      cmp_n   = out_cmp;
      beat_n  = out_beat;
      last_n  = out_last;
      load    = 1'b0;
      case (state)
         IDLE:  load = in_valid;
         ISSUE: begin
            if (out_ready) begin
               if (!out_last) begin
                  beat_n = out_beat + BW'(1);
                  last_n = (beat_n == LAST_BEAT);
               end else if (in_valid) begin
                  load = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
`ifdef VEC_DECO_ILLEGAL_TRAP_EN
      illegal_n = illegal;
      do_load   = load && dec_legal;
      if (load && !dec_legal) begin
         illegal_n = 1'b1;
         state_n   = IDLE;
      end
`else
      do_load = load;
`endif
      if (do_load) begin
         state_n = ISSUE;
         alu_n   = dec_alu;
         wr_n    = dec_wr;
         cmp_n   = dec_cmp;
         beat_n  = '0;
         last_n  = !dec_vec || (NBEATS == 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         out_alu  <= 3'b000;
         out_wr   <= 1'b0;
         out_cmp  <= 1'b0;
         out_beat <= '0;
         out_last <= 1'b0;
`ifdef VEC_DECO_ILLEGAL_TRAP_EN
         illegal  <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         out_alu  <= alu_n;
         out_wr   <= wr_n;
         out_cmp  <= cmp_n;
         out_beat <= beat_n;
         out_last <= last_n;
`ifdef VEC_DECO_ILLEGAL_TRAP_EN
         illegal  <= illegal_n;
`endif
      end
   end

endmodule

// File: tb/tb_vec_inst_decode.sv
// Directed bench for vec_inst_decode with default parameters (two beats per vector op).
// Honours VEC_DECO_ILLEGAL_TRAP_EN the same way the design does.
module tb_vec_inst_decode;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_opcode;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_alu;
   logic       out_wr;
   logic       out_cmp;
   logic [0:0] out_beat;
   logic       out_last;
`ifdef VEC_DECO_ILLEGAL_TRAP_EN
   logic       illegal;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   vec_inst_decode dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_opcode(in_opcode), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu(out_alu), .out_wr(out_wr), .out_cmp(out_cmp),
      .out_beat(out_beat), .out_last(out_last)
`ifdef VEC_DECO_ILLEGAL_TRAP_EN
      ,.illegal(illegal)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Full beat check: valid, alu, wr, cmp, beat, last.
   task automatic check_beat(input string tag, input logic v, input logic [2:0] alu,
                             input logic wr, input logic cmp, input logic beat, input logic last);
      check({tag, ".valid"}, 8'(out_valid), 8'(v));
      check({tag, ".alu"},   8'(out_alu),   8'(alu));
      check({tag, ".wr"},    8'(out_wr),    8'(wr));
      check({tag, ".cmp"},   8'(out_cmp),   8'(cmp));
      check({tag, ".beat"},  8'(out_beat),  8'(beat));
      check({tag, ".last"},  8'(out_last),  8'(last));
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_opcode = 4'b1000;
      out_ready = 1'b1;

      // Reset held with an opcode offered
      tick();
      tick();
      check_beat("reset", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset.in_ready", 8'(in_ready), 8'd1);
`ifdef VEC_DECO_ILLEGAL_TRAP_EN
      check("reset.illegal", 8'(illegal), 8'd0);
`endif

      // ADD: first edge after release accepts
      rst = 1'b0;
      tick();
      check_beat("add.b0", 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
      check("add.b0.in_ready", 8'(in_ready), 8'd0);
      in_valid = 1'b0;
      tick();
      check_beat("add.b1", 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
      check("add.b1.in_ready", 8'(in_ready), 8'd1);
      tick();
      check("add.idle", 8'(out_valid), 8'd0);

      // CMPI then SUB back-to-back
      in_valid = 1'b1;
      in_opcode = 4'b0110;
      tick();
      check_beat("cmpi", 1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1);
      check("cmpi.in_ready", 8'(in_ready), 8'd1);
      in_opcode = 4'b1001;
      tick();
      check_beat("sub.b0", 1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      tick();
      check_beat("sub.b1", 1'b1, 3'b011, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check("sub.idle", 8'(out_valid), 8'd0);

      // MUL stalled on beat 0 for three cycles
      in_valid = 1'b1;
      in_opcode = 4'b1010;
      tick();
      check_beat("mul.b0", 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_beat("mul.stall", 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
         check("mul.stall.in_ready", 8'(in_ready), 8'd0);
      end
      out_ready = 1'b1;
      check("mul.ready.in_ready", 8'(in_ready), 8'd0);
      tick();
      check_beat("mul.b1", 1'b1, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check("mul.idle", 8'(out_valid), 8'd0);

      // MOVI then scalar 0000, back-to-back
      in_valid = 1'b1;
      in_opcode = 4'b1111;
      tick();
      check_beat("movi.b0", 1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_beat("movi.b1", 1'b1, 3'b111, 1'b1, 1'b0, 1'b1, 1'b1);
      in_opcode = 4'b0000;
      tick();
      check_beat("op0000", 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);
      in_opcode = 4'b0100;
      tick();
      check_beat("str", 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b0;
      tick();
      check("str.idle", 8'(out_valid), 8'd0);

      // Unmapped opcode 0011
      in_valid = 1'b1;
      in_opcode = 4'b0011;
      tick();
`ifdef VEC_DECO_ILLEGAL_TRAP_EN
      check("ill.valid", 8'(out_valid), 8'd0);
      check("ill.flag", 8'(illegal), 8'd1);
      in_valid = 1'b0;
      tick();
      check("ill.valid2", 8'(out_valid), 8'd0);
      check("ill.sticky", 8'(illegal), 8'd1);
`else
      check_beat("nop", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b0;
      tick();
      check("nop.idle", 8'(out_valid), 8'd0);
`endif

      // Reset during DIV beat 0
      in_valid = 1'b1;
      in_opcode = 4'b1011;
      tick();
      check_beat("div.b0", 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_beat("div.rst", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef VEC_DECO_ILLEGAL_TRAP_EN
      check("div.rst.illegal", 8'(illegal), 8'd0);
`endif
      tick();
      rst = 1'b0;
      tick();
      check_beat("div.after", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      check("div.after.in_ready", 8'(in_ready), 8'd1);
      tick();
      check("div.after2.valid", 8'(out_valid), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vec_inst_decode.md
# vec_inst_decode

Pipelined, handshaked instruction-decode stage for the vector ALU path of the alpha-composition ASIP. It translates the 4-bit opcode into the 3-bit ALU control code and register-write/compare qualifiers. For vector opcodes it sequences the instruction into `VLEN/LANES` lane-group beats toward the execute stage. Scalar opcodes issue one beat. It sits between the fetch/issue queue and the vector ALU.

## Interface
Parameters:
- `VLEN`, 8: elements per vector register.
- `LANES`, 4: elements processed per beat. `VLEN % LANES == 0` is required.
- `BW`, `$clog2(VLEN/LANES)` with a minimum of 1: beat index width (localparam).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: opcode offered.
- `in_opcode`, in, 4: instruction opcode.
- `in_ready`, out, 1: stage accepts an opcode this cycle.
- `out_valid`, out, 1: beat presented to execute.
- `out_ready`, in, 1: execute consumes the beat.
- `out_alu`, out, 3: ALU control code.
- `out_wr`, out, 1: result is written to the register file.
- `out_cmp`, out, 1: beat updates flags and writes no result.
- `out_beat`, out, BW: lane-group index. Lanes covered are `out_beat*LANES` to `+LANES-1`.
- `out_last`, out, 1: final beat of the instruction.
- `illegal`, out, 1: sticky illegal-opcode flag. Present only with the macro; see Configuration.

## Operation
Decode map (opcode -> alu, wr, cmp, vector):
- STR 0100 -> 001, 0, 0, scalar.
- LDR 1101 -> 001, 1, 0, vector.
- MOVR 1110 -> 001, 1, 0, vector.
- MOVI 1111 -> 111, 1, 0, vector.
- ADD 1000 -> 010, 1, 0, vector.
- SUB 1001 -> 011, 1, 0, vector.
- MUL 1010 -> 100, 1, 0, vector.
- DIV 1011 -> 101, 1, 0, vector.
- CMPR 0101 -> 011, 0, 1, scalar.
- CMPI 0110 -> 011, 0, 1, scalar.
- 0000 and 0001 -> 010, 1, 0, scalar.
- All other opcodes -> 000, 0, 0, scalar (NOP).

Issue rules:
- A vector instruction issues `VLEN/LANES` beats. Beat indices are 0, 1, … in order, and `out_last` is set on the final beat.
- A scalar instruction issues one beat with index 0 and `out_last`=1.

FSM:
- IDLE: no beat held. `in_ready`=1. On `in_valid`, the stage registers the decode, sets beat 0, and goes to ISSUE.
- ISSUE: `out_valid`=1. On `out_ready` with `!out_last`, the beat increments and the state stays ISSUE.
- ISSUE, `out_ready` and `out_last`, with a new `in_valid`: the new instruction is loaded at beat 0 and the state stays ISSUE (back-to-back).
- ISSUE, `out_ready` and `out_last`, without `in_valid`: go to IDLE.

Handshake:
- `in_ready` = IDLE, or (ISSUE && `out_last` && `out_ready`).
- While `out_ready`=0, all `out_*` signals are held stable.
- `out_alu`, `out_wr`, `out_cmp` and the instruction class do not change within an instruction. Only `out_beat` and `out_last` advance.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_alu`=000, `out_wr`=0, `out_cmp`=0, `out_beat`=0, `out_last`=0, `illegal`=0. All outputs are registered.
- Accept-to-first-beat latency: 1 cycle (`out_valid` rises on the edge that accepts).
- Throughput: one beat per cycle with `out_ready` held high. A vector instruction occupies `VLEN/LANES` cycles. With default parameters a stream of vector ops sustains one instruction per 2 cycles, and a stream of scalar ops sustains one per cycle.
- Reset mid-instruction: the in-flight beat is lost immediately (asynchronous), and the remaining beats are discarded.
- `VLEN==LANES`: every instruction is single-beat, and `out_beat` stays 0.
- `out_beat` never wraps. It resets to 0 only when a new instruction loads.

## Configuration
- `VEC_DECO_ILLEGAL_TRAP_EN` defined:
  - Unmapped opcodes are accepted but produce no beat; the stage stays IDLE.
  - `illegal` goes to 1 the cycle after acceptance and stays 1 until `rst`.
- `VEC_DECO_ILLEGAL_TRAP_EN` undefined:
  - Unmapped opcodes issue one NOP beat (000, wr=0, cmp=0, last=1).
  - The `illegal` port is absent.

## Test plan
- Reset with `in_valid`=1: all outputs hold their reset values while `rst`=1. The first accept happens on the first edge after `rst` falls.
- ADD (1000) with defaults, `out_ready`=1: beats (alu 010, wr 1, beat 0, last 0), then (beat 1, last 1). `in_ready` is 1 on the second beat.
- CMPI (0110) followed by SUB (1001), back-to-back: CMPI gives one beat (011, cmp 1, wr 0, last 1). SUB's beat 0 follows the next cycle with no bubble.
- MUL (1010) with `out_ready` low for 3 cycles on beat 0: the outputs stay frozen and `in_ready`=0. Beat 1 appears one cycle after `out_ready` rises.
- Opcode 0011: with the macro, no `out_valid` and `illegal`=1 from the next cycle onward. Without the macro, a single 000 beat with last=1.
- `rst` asserted during beat 0 of DIV (1011): `out_valid` drops at once, and after release the stage is IDLE with no residual beat 1.
